// File: rtl/scpu_sram_scan_port.sv
// scpu_sram_scan_port: serial scan load/readback port and CPU/scan SRAM arbiter.
// Define SRAM_SCAN_CKSUM_EN to add the CKSUM session checksum output.
module scpu_sram_scan_port #(
  parameter int MEMORY_DATA_WIDTH = 8,
  parameter int MEMORY_ADDR_WIDTH = 10
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [1:0]                   CTRL_MODE,
  input  logic                         CTRL_BGN,
  input  logic                         LOAD_N,
  input  logic                         CTRL_SI,
  output logic                         CTRL_SO,
  output logic                         CTRL_RDY,
  output logic                         CPU_STALL,
  input  logic                         CPU_CEN,
  input  logic                         CPU_WEN,
  input  logic [MEMORY_ADDR_WIDTH-1:0] CPU_A,
  input  logic [MEMORY_DATA_WIDTH-1:0] CPU_D,
  output logic                         CEN_after_mux,
  output logic                         WEN_after_mux,
  output logic [MEMORY_ADDR_WIDTH-1:0] A_after_mux,
  output logic [MEMORY_DATA_WIDTH-1:0] D_after_mux,
  input  logic [MEMORY_DATA_WIDTH-1:0] Q_from_SRAM
`ifdef SRAM_SCAN_CKSUM_EN
  ,
  output logic [MEMORY_DATA_WIDTH-1:0] CKSUM
`endif
);
  localparam int DW = MEMORY_DATA_WIDTH;
  localparam int AW = MEMORY_ADDR_WIDTH;
  typedef enum logic [2:0] {IDLE, ADDR, WDATA, RFETCH, RLOAD, RDATA} state_t;
  state_t        state_q;
  logic          rd_q, wr_pend_q;
  logic [5:0]    cnt_q, cnt_d;
  logic [AW-1:0] ptr_q, ptr_inc, ptr_sh;
  logic [DW-1:0] shreg_q, wbuf_q, word_sh;
  logic          busy, start, last_a, last_d, rd_ahead, load;
  always_comb begin
    busy          = state_q != IDLE;
    start         = !busy && CTRL_BGN && (CTRL_MODE == 2'b01 || CTRL_MODE == 2'b10);
    last_a        = cnt_q == 6'(AW - 1);
    last_d        = cnt_q == 6'(DW - 1);
    cnt_d         = (state_q == ADDR ? last_a : last_d) ? '0 : cnt_q + 6'd1;
    ptr_inc       = ptr_q + AW'(1);
    ptr_sh        = AW'({ptr_q, CTRL_SI});
    word_sh       = {shreg_q[DW-2:0], CTRL_SI};
    // prefetch the next word so it arrives exactly as the last bit leaves
    rd_ahead      = state_q == RDATA && !LOAD_N && cnt_q == 6'(DW - 2);
    load          = !LOAD_N && (state_q == RLOAD || (state_q == RDATA && last_d));
    CTRL_RDY      = !busy;
    CPU_STALL     = busy;
    CTRL_SO       = state_q == RDATA && shreg_q[DW-1];
    CEN_after_mux = busy ? !(wr_pend_q || state_q == RFETCH || rd_ahead) : CPU_CEN;
    WEN_after_mux = busy ? !wr_pend_q : CPU_WEN;
    A_after_mux   = busy ? ptr_q : CPU_A;
    D_after_mux   = busy ? wbuf_q : CPU_D;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      rd_q      <= 1'b0;
      cnt_q     <= '0;
      ptr_q     <= '0;
      shreg_q   <= '0;
      wbuf_q    <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      // a buffered word is written even in the cycle a session aborts
      if (wr_pend_q) begin
        ptr_q     <= ptr_inc;
        wr_pend_q <= 1'b0;
      end
      if (!busy) begin
        if (start) begin
          state_q <= ADDR;
          rd_q    <= CTRL_MODE[1];
          cnt_q   <= '0;
        end
      end else if (LOAD_N) begin
        state_q <= IDLE;
      end else begin
        case (state_q)
          ADDR: begin
            ptr_q <= ptr_sh;
            cnt_q <= cnt_d;
            if (last_a) state_q <= rd_q ? RFETCH : WDATA;
          end
          WDATA: begin
            shreg_q <= word_sh;
            cnt_q   <= cnt_d;
            if (last_d) begin
              wbuf_q    <= word_sh;
              wr_pend_q <= 1'b1;
            end
          end
          RFETCH: state_q <= RLOAD;
          RLOAD, RDATA: begin
            shreg_q <= load ? Q_from_SRAM : shreg_q << 1;
            if (load) ptr_q <= ptr_inc;
            if (state_q == RDATA) cnt_q <= cnt_d;
            else state_q <= RDATA;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end
`ifdef SRAM_SCAN_CKSUM_EN
  logic [DW-1:0] cksum_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) cksum_q <= '0;
    else if (start) cksum_q <= '0;
    else if (wr_pend_q) cksum_q <= cksum_q ^ wbuf_q;
    else if (load) cksum_q <= cksum_q ^ Q_from_SRAM;
  end
  assign CKSUM = cksum_q;
`endif
endmodule

// File: tb/tb_scpu_sram_scan_port.sv
// tb_scpu_sram_scan_port: table vectors, directed bursts and randomized sessions against an SRAM model.
module tb_scpu_sram_scan_port;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int N  = 1 << AW;
  logic          clk = 1'b0, rst = 1'b1;
  logic [1:0]    mode_i = 2'b00;
  logic          bgn_i = 1'b0, ln_i = 1'b1, si_i = 1'b0;
  logic          so, rdy, stall;
  logic          cpu_cen = 1'b1, cpu_wen = 1'b1;
  logic [AW-1:0] cpu_a = '0;
  logic [DW-1:0] cpu_d = '0;
  logic          cen_m, wen_m;
  logic [AW-1:0] a_m;
  logic [DW-1:0] d_m, q;
`ifdef SRAM_SCAN_CKSUM_EN
  logic [DW-1:0] cksum;
`endif
  logic [DW-1:0] mem [N];
  logic [DW-1:0] ref_mem [N];
  logic [DW-1:0] wq [8];
  logic [DW-1:0] exp_ck;
  logic          hold_en = 1'b0, rand_en = 1'b0;
  int            n_chk = 0, n_fail = 0;

  scpu_sram_scan_port #(.MEMORY_DATA_WIDTH(DW), .MEMORY_ADDR_WIDTH(AW)) dut (
    .CLK(clk), .RST(rst), .CTRL_MODE(mode_i), .CTRL_BGN(bgn_i), .LOAD_N(ln_i),
    .CTRL_SI(si_i), .CTRL_SO(so), .CTRL_RDY(rdy), .CPU_STALL(stall),
    .CPU_CEN(cpu_cen), .CPU_WEN(cpu_wen), .CPU_A(cpu_a), .CPU_D(cpu_d),
    .CEN_after_mux(cen_m), .WEN_after_mux(wen_m), .A_after_mux(a_m), .D_after_mux(d_m),
    .Q_from_SRAM(q)
`ifdef SRAM_SCAN_CKSUM_EN
    , .CKSUM(cksum)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (!cen_m) begin
      if (!wen_m) mem[a_m] <= d_m;
      else q <= mem[a_m];
    end

  typedef struct {
    logic bgn; logic [1:0] mode; logic ln;
    logic cen, wen; logic [AW-1:0] a; logic [DW-1:0] d;
    logic rdy;
  } vec_t;
  vec_t tv [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic bgn, input logic [1:0] mode, input logic ln, input logic si, input logic busy);
    @(negedge clk);
    bgn_i = bgn; mode_i = mode; ln_i = ln; si_i = si;
    if (!busy || !(hold_en || rand_en)) begin
      cpu_cen = 1'b1; cpu_wen = 1'b1;
    end else if (hold_en) begin
      cpu_cen = 1'b0; cpu_wen = 1'b0; cpu_a = 10'h010; cpu_d = 8'h11;
    end else begin
      cpu_cen = 1'($urandom); cpu_wen = 1'($urandom);
      cpu_a = AW'($urandom); cpu_d = DW'($urandom);
    end
    #1;
  endtask

  task automatic scan_write(input logic [AW-1:0] base, input int nw, input int part);
    int slot, pend, pend_slot, nb, nf;
    drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    chk("wr_bgn_rdy", rdy, 1'b1);
    for (int i = 0; i < AW; i++) begin
      drive(1'b0, 2'b00, 1'b0, base[AW-1-i], 1'b1);
      chk("wr_addr_bus", {rdy, stall, cen_m, wen_m}, 4'b0111);
    end
    slot = 0; pend = -1; pend_slot = -1;
    for (int w = 0; w <= nw; w++) begin
      nb = (w == nw) ? 1 : (w == nw - 1 && part > 0) ? part : DW;
      for (int b = 0; b < nb; b++) begin
        drive(1'b0, 2'b00, w == nw, w == nw ? 1'b0 : wq[w][DW-1-b], 1'b1);
        if (pend >= 0 && slot == pend_slot) begin
          chk("wr_issue", {cen_m, wen_m, a_m, d_m}, {2'b00, AW'(base + pend), wq[pend]});
          pend = -1;
        end else chk("wr_idle_bus", {cen_m, wen_m}, 2'b11);
        if (w < nw && b == DW - 1) begin
          pend = w; pend_slot = slot + 1;
        end
        slot++;
      end
    end
    chk("wr_abort_busy", rdy, 1'b0);
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("wr_abort_rdy", {rdy, stall, so, cen_m}, 4'b1001);
    nf = part > 0 ? nw - 1 : nw;
    exp_ck = '0;
    for (int w = 0; w < nf; w++) begin
      ref_mem[AW'(base + w)] = wq[w];
      exp_ck ^= wq[w];
    end
`ifdef SRAM_SCAN_CKSUM_EN
    chk("wr_cksum", cksum, exp_ck);
`endif
  endtask

  task automatic scan_read(input logic [AW-1:0] base, input int nw);
    drive(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
    chk("rd_bgn_rdy", rdy, 1'b1);
    for (int i = 0; i < AW; i++) begin
      drive(1'b0, 2'b00, 1'b0, base[AW-1-i], 1'b1);
      chk("rd_addr_bus", {rdy, stall, cen_m, wen_m, so}, 5'b01110);
    end
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("rd_fetch", {so, cen_m, wen_m, a_m}, {3'b001, base});
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    chk("rd_load", {so, cen_m, wen_m}, 3'b011);
    for (int w = 0; w < nw; w++)
      for (int b = 0; b < DW; b++) begin
        drive(1'b0, 2'b00, 1'b0, 1'($urandom), 1'b1);
        chk("rd_so", so, ref_mem[AW'(base + w)][DW-1-b]);
        if (b == DW - 2) chk("rd_ahead", {cen_m, wen_m, a_m}, {2'b01, AW'(base + w + 1)});
        else chk("rd_idle_bus", {cen_m, wen_m}, 2'b11);
      end
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b1);
    chk("rd_abort_busy", rdy, 1'b0);
    drive(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
    chk("rd_abort_rdy", {rdy, stall, so}, 3'b100);
    exp_ck = '0;
    for (int w = 0; w <= nw; w++) exp_ck ^= ref_mem[AW'(base + w)];
`ifdef SRAM_SCAN_CKSUM_EN
    chk("rd_cksum", cksum, exp_ck);
`endif
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    cpu_cen = 1'b0; cpu_wen = 1'b0; cpu_a = a; cpu_d = d; #1;
    chk("cpu_pass", {stall, cen_m, wen_m, a_m, d_m}, {3'b000, a, d});
    @(negedge clk);
    cpu_cen = 1'b1; cpu_wen = 1'b1; #1;
    chk("cpu_mem", mem[a], d);
    ref_mem[a] = d;
  endtask

  initial begin : main
    logic [DW-1:0] v;
    logic [AW-1:0] base;
    int nw, part, bad;
    for (int i = 0; i < N; i++) begin
      v = (i == 'h010 || i == 'h100) ? '0 : DW'($urandom);
      mem[i] <= v;
      ref_mem[i] = v;
    end
    cpu_cen = 1'b0; cpu_a = 10'h155; cpu_d = 8'h5A;
    #1;
    chk("rst_state", {rdy, stall, so}, 3'b100);
    chk("rst_pass", {cen_m, wen_m, a_m, d_m}, {2'b01, 10'h155, 8'h5A});
`ifdef SRAM_SCAN_CKSUM_EN
    chk("rst_cksum", cksum, 8'h00);
`endif
    @(negedge clk); @(negedge clk);
    rst = 1'b0; cpu_cen = 1'b1;

    tv[0] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 10'h010, 8'h11, 1'b1};
    tv[1] = '{1'b1, 2'b00, 1'b0, 1'b1, 1'b1, 10'h3FF, 8'hFF, 1'b1};
    tv[2] = '{1'b0, 2'b01, 1'b0, 1'b0, 1'b1, 10'h155, 8'h5A, 1'b1};
    tv[3] = '{1'b1, 2'b11, 1'b0, 1'b1, 1'b1, 10'h2AA, 8'hA5, 1'b1};
    tv[4] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 10'h001, 8'h00, 1'b1};
    tv[5] = '{1'b1, 2'b01, 1'b1, 1'b1, 1'b1, 10'h000, 8'h00, 1'b1};
    tv[6] = '{1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 10'h010, 8'h11, 1'b0};
    tv[7] = '{1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 10'h010, 8'h11, 1'b0};
    tv[8] = '{1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 10'h010, 8'h11, 1'b0};
    tv[9] = '{1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 10'h020, 8'h33, 1'b1};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bgn_i = tv[i].bgn; mode_i = tv[i].mode; ln_i = tv[i].ln; si_i = 1'b0;
      cpu_cen = tv[i].cen; cpu_wen = tv[i].wen; cpu_a = tv[i].a; cpu_d = tv[i].d;
      #1;
      chk("vec_rdy", {rdy, stall, so}, {tv[i].rdy, !tv[i].rdy, 1'b0});
      if (tv[i].rdy) chk("vec_pass", {cen_m, wen_m, a_m, d_m}, {tv[i].cen, tv[i].wen, tv[i].a, tv[i].d});
      else chk("vec_scan", {cen_m, wen_m}, 2'b11);
    end
    chk("vec_blocked", mem[10'h010], 8'h00);

    wq[0] = 8'hA5; wq[1] = 8'h3C; wq[2] = 8'h7E;
    scan_write(10'h3FE, 3, 0);
    chk("burst_3fe", mem[10'h3FE], 8'hA5);
    chk("burst_3ff", mem[10'h3FF], 8'h3C);
    chk("burst_wrap", mem[10'h000], 8'h7E);
    drive(1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    chk("mode00_ignored", {rdy, stall}, 2'b10);
`ifdef SRAM_SCAN_CKSUM_EN
    chk("cksum_e7", cksum, 8'hE7);
`endif
    scan_read(10'h3FE, 3);

    wq[0] = 8'h5A; wq[1] = 8'hC3;
    scan_write(10'h200, 2, 5);
    chk("abort_first", mem[10'h200], 8'h5A);
    chk("abort_second", mem[10'h201], ref_mem[10'h201]);

    hold_en = 1'b1;
    wq[0] = 8'h99;
    scan_write(10'h040, 1, 0);
    hold_en = 1'b0;
    chk("arb_blocked", mem[10'h010], 8'h00);
    cpu_write(10'h010, 8'h11);

    drive(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
    base = 10'h100;
    for (int i = 0; i < AW; i++) drive(1'b0, 2'b00, 1'b0, base[AW-1-i], 1'b1);
    v = 8'hF0;
    for (int b = 0; b < DW; b++) drive(1'b0, 2'b00, 1'b0, v[DW-1-b], 1'b1);
    @(negedge clk);
    rst = 1'b1; #1;
    chk("rst_mid_state", {rdy, stall, so}, 3'b100);
    chk("rst_mid_pass", {cen_m, wen_m}, {cpu_cen, cpu_wen});
    @(negedge clk);
    rst = 1'b0; ln_i = 1'b1; #1;
    chk("rst_mid_nowrite", mem[10'h100], ref_mem[10'h100]);

    for (int it = 0; it < 25; it++) begin
      rand_en = 1'b1;
      base = AW'($urandom);
      nw = $urandom_range(4, 1);
      for (int w = 0; w < nw; w++) wq[w] = DW'($urandom);
      part = ($urandom_range(1, 0) == 1) ? 0 : $urandom_range(DW - 1, 1);
      scan_write(base, nw, part);
      if (part > 0) nw--;
      if (nw > 0) scan_read(base, nw);
      rand_en = 1'b0;
      cpu_write(AW'($urandom), DW'($urandom));
    end

    bad = 0;
    for (int i = 0; i < N; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_final", bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
